// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline register: default
// redirect/reset PCs, ExcCode values and the occupancy FSM encoding.
package pipe_pkg;

    localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    // Number of entries held in a given FSM state.
    function automatic logic [1:0] state_occ(input state_e st);
        case (st)
            ST_EMPTY: return 2'd0;
            ST_ONE:   return 2'd1;
            ST_TWO:   return 2'd2;
            default:  return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// One valid/ready channel carrying a pipeline entry {pc, data, exc, bd}.
// master drives the entry, slave returns ready.
interface pipe_stage_skid_if #(
    parameter int DATA_W = 128,
    parameter int PC_W   = 32,
    parameter int EXC_W  = 5
);
    logic              valid;
    logic              ready;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] data;
    logic [EXC_W-1:0]  exc;
    logic              bd;

    modport master (output valid, output pc, output data, output exc, output bd, input ready);
    modport slave  (input valid, input pc, input data, input exc, input bd, output ready);
endinterface

// File: rtl/pipe_skid_buf.sv
// Second storage slot of the pipeline register. Holds the entry that
// arrived while the output register was stalled.
module pipe_skid_buf #(
    parameter int DATA_W = 128,
    parameter int PC_W   = 32,
    parameter int EXC_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              load,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_data,
    input  logic [EXC_W-1:0]  in_exc,
    input  logic              in_bd,
    output logic [PC_W-1:0]   skid_pc,
    output logic [DATA_W-1:0] skid_data,
    output logic [EXC_W-1:0]  skid_exc,
    output logic              skid_bd
);
    logic [PC_W-1:0]   pc_q,   pc_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [EXC_W-1:0]  exc_q,  exc_d;
    logic              bd_q,   bd_d;

    // Next slot contents: clear on kill, capture on load, otherwise hold.
    always_comb begin
        pc_d   = pc_q;
        data_d = data_q;
        exc_d  = exc_q;
        bd_d   = bd_q;
        if (clr) begin
            pc_d   = '0;
            data_d = '0;
            exc_d  = '0;
            bd_d   = 1'b0;
        end else if (load) begin
            pc_d   = in_pc;
            data_d = in_data;
            exc_d  = in_exc;
            bd_d   = in_bd;
        end else begin
            pc_d   = pc_q;
        end
    end

    // Slot register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q   <= '0;
            data_q <= '0;
            exc_q  <= '0;
            bd_q   <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            data_q <= data_d;
            exc_q  <= exc_d;
            bd_q   <= bd_d;
        end
    end

    assign skid_pc   = pc_q;
    assign skid_data = data_q;
    assign skid_exc  = exc_q;
    assign skid_bd   = bd_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register (D->E, E->M, M->W) with valid/ready
// handshake, exception redirect (req) and flush-to-bubble.
// Build option PIPE_SKID_EN: adds a second entry (skid slot) so in_ready
// is a flop with no combinational path from out_ready. Without it the
// block is a single register with in_ready = ~out_valid | out_ready.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int              DATA_W   = 128,
    parameter int              PC_W     = 32,
    parameter int              EXC_W    = 5,
    parameter logic [PC_W-1:0] EXC_VEC  = PC_W'(EXC_VEC_DEF),
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req,
    input  logic                    flush,
    pipe_stage_skid_if.slave        up,
    pipe_stage_skid_if.master       dn,
    output logic [1:0]              occ
);
    state_e            state_q,     state_d;
    logic              out_valid_q, out_valid_d;
    logic [PC_W-1:0]   out_pc_q,    out_pc_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [EXC_W-1:0]  out_exc_q,   out_exc_d;
    logic              out_bd_q,    out_bd_d;

    logic in_ready_s;
    logic accept_s;
    logic drain_s;

`ifdef PIPE_SKID_EN
    logic              in_ready_q, in_ready_d;
    logic              skid_load_s;
    logic              skid_clr_s;
    logic [PC_W-1:0]   skid_pc_s;
    logic [DATA_W-1:0] skid_data_s;
    logic [EXC_W-1:0]  skid_exc_s;
    logic              skid_bd_s;

    pipe_skid_buf #(
        .DATA_W (DATA_W),
        .PC_W   (PC_W),
        .EXC_W  (EXC_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .clr       (skid_clr_s),
        .load      (skid_load_s),
        .in_pc     (up.pc),
        .in_data   (up.data),
        .in_exc    (up.exc),
        .in_bd     (up.bd),
        .skid_pc   (skid_pc_s),
        .skid_data (skid_data_s),
        .skid_exc  (skid_exc_s),
        .skid_bd   (skid_bd_s)
    );

    assign in_ready_s = in_ready_q;
`else
    assign in_ready_s = ~out_valid_q | dn.ready;
`endif

    assign accept_s = up.valid & in_ready_s;
    assign drain_s  = out_valid_q & dn.ready;

    // Next state and output register: req > flush > handshake.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_data_d  = out_data_q;
        out_exc_d   = out_exc_q;
        out_bd_d    = out_bd_q;
`ifdef PIPE_SKID_EN
        skid_load_s = 1'b0;
        skid_clr_s  = 1'b0;
`endif
        if (req) begin
            // Redirect to the exception vector; everything held is killed.
            state_d     = ST_EMPTY;
            out_valid_d = 1'b0;
            out_pc_d    = EXC_VEC;
            out_data_d  = '0;
            out_exc_d   = '0;
            out_bd_d    = 1'b0;
`ifdef PIPE_SKID_EN
            skid_clr_s  = 1'b1;
`endif
        end else if (flush) begin
            // Bubble keeps PC/BD so CP0 still sees a meaningful EPC/BD.
            state_d     = ST_EMPTY;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_exc_d   = '0;
`ifdef PIPE_SKID_EN
            skid_clr_s  = 1'b1;
`endif
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_d     = ST_ONE;
                        out_valid_d = 1'b1;
                        out_pc_d    = up.pc;
                        out_data_d  = up.data;
                        out_exc_d   = up.exc;
                        out_bd_d    = up.bd;
                    end else begin
                        state_d     = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && drain_s) begin
                        state_d     = ST_ONE;
                        out_valid_d = 1'b1;
                        out_pc_d    = up.pc;
                        out_data_d  = up.data;
                        out_exc_d   = up.exc;
                        out_bd_d    = up.bd;
                    end else if (accept_s) begin
`ifdef PIPE_SKID_EN
                        // Output stalled: park the new entry in the skid slot.
                        state_d     = ST_TWO;
                        skid_load_s = 1'b1;
`else
                        // in_ready forces drain whenever accepting here.
                        state_d     = ST_ONE;
`endif
                    end else if (drain_s) begin
                        state_d     = ST_EMPTY;
                        out_valid_d = 1'b0;
                        out_data_d  = '0;
                        out_exc_d   = '0;
                    end else begin
                        state_d     = ST_ONE;
                    end
                end
                ST_TWO: begin
`ifdef PIPE_SKID_EN
                    if (drain_s) begin
                        // Skid entry moves to the output on the same edge.
                        state_d     = ST_ONE;
                        out_valid_d = 1'b1;
                        out_pc_d    = skid_pc_s;
                        out_data_d  = skid_data_s;
                        out_exc_d   = skid_exc_s;
                        out_bd_d    = skid_bd_s;
                    end else begin
                        state_d     = ST_TWO;
                    end
`else
                    state_d     = ST_EMPTY;
                    out_valid_d = 1'b0;
                    out_data_d  = '0;
                    out_exc_d   = '0;
`endif
                end
                default: begin
                    state_d     = ST_EMPTY;
                    out_valid_d = 1'b0;
                    out_data_d  = '0;
                    out_exc_d   = '0;
                end
            endcase
        end
`ifdef PIPE_SKID_EN
        in_ready_d = (state_d != ST_TWO);
`endif
    end

    // State and output register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            out_pc_q    <= RESET_PC;
            out_data_q  <= '0;
            out_exc_q   <= '0;
            out_bd_q    <= 1'b0;
`ifdef PIPE_SKID_EN
            in_ready_q  <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_data_q  <= out_data_d;
            out_exc_q   <= out_exc_d;
            out_bd_q    <= out_bd_d;
`ifdef PIPE_SKID_EN
            in_ready_q  <= in_ready_d;
`endif
        end
    end

    assign up.ready = in_ready_s;
    assign dn.valid = out_valid_q;
    assign dn.pc    = out_pc_q;
    assign dn.data  = out_data_q;
    assign dn.exc   = out_exc_q;
    assign dn.bd    = out_bd_q;
    assign occ      = state_occ(state_q);

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: reference occupancy model plus a
// FIFO scoreboard of accepted entries, and directed scenario tasks.
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    typedef struct {
        logic [31:0]  pc;
        logic [127:0] data;
        logic [4:0]   exc;
        logic         bd;
    } ent_t;

    logic       clk;
    logic       reset_n;
    logic       req;
    logic       flush;
    logic [1:0] occ;

    int checks;
    int errors;
    ent_t sb[$];

    pipe_stage_skid_if #(.DATA_W(128), .PC_W(32), .EXC_W(5)) up_if ();
    pipe_stage_skid_if #(.DATA_W(128), .PC_W(32), .EXC_W(5)) dn_if ();

    pipe_stage_skid dut (
        .clk   (clk),
        .reset (reset_n),
        .req   (req),
        .flush (flush),
        .up    (up_if.slave),
        .dn    (dn_if.master),
        .occ   (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef PIPE_SKID_EN
    localparam int MAX_OCC = 2;
`else
    localparam int MAX_OCC = 1;
`endif

    task automatic drive(input bit v, input logic [31:0] pc, input logic [4:0] exc, input bit bd);
        up_if.valid = v;
        up_if.pc    = pc;
        up_if.data  = v ? {$urandom(), $urandom(), $urandom(), $urandom()} : 128'd0;
        up_if.exc   = exc;
        up_if.bd    = bd;
    endtask

    // One clock: compare DUT against the model just before the edge, update model, step.
    task automatic cycle();
        bit   m_rdy;
        bit   acc;
        bit   drn;
        ent_t e;
        @(negedge clk);
        if (!reset_n || req || flush) begin
            sb.delete();
        end else begin
`ifdef PIPE_SKID_EN
            m_rdy = (sb.size() != 2);
`else
            m_rdy = (sb.size() == 0) || dn_if.ready;
`endif
            checks++;
            if (up_if.ready !== m_rdy) begin
                errors++;
                $display("FAIL in_ready got %b exp %b", up_if.ready, m_rdy);
            end
            checks++;
            if (occ !== 2'(sb.size())) begin
                errors++;
                $display("FAIL occ got %0d exp %0d", occ, sb.size());
            end
            checks++;
            if (dn_if.valid !== (sb.size() != 0)) begin
                errors++;
                $display("FAIL out_valid got %b exp %b", dn_if.valid, sb.size() != 0);
            end
            if (sb.size() != 0) begin
                checks++;
                if (dn_if.pc !== sb[0].pc || dn_if.data !== sb[0].data ||
                    dn_if.exc !== sb[0].exc || dn_if.bd !== sb[0].bd) begin
                    errors++;
                    $display("FAIL sb_entry got pc %h data %h exc %0d bd %b exp pc %h data %h exc %0d bd %b",
                             dn_if.pc, dn_if.data, dn_if.exc, dn_if.bd,
                             sb[0].pc, sb[0].data, sb[0].exc, sb[0].bd);
                end
            end else begin
                checks++;
                if (dn_if.data !== 128'd0 || dn_if.exc !== 5'd0) begin
                    errors++;
                    $display("FAIL bubble_clean got data %h exc %0d exp 0 0", dn_if.data, dn_if.exc);
                end
            end
            drn = (sb.size() != 0) && dn_if.ready;
            acc = up_if.valid && m_rdy;
            if (drn) void'(sb.pop_front());
            if (acc) begin
                e.pc = up_if.pc; e.data = up_if.data; e.exc = up_if.exc; e.bd = up_if.bd;
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cycle();
        cycle();
        reset_n = 1'b1;
        checks++;
        if (dn_if.valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", dn_if.valid); end
        checks++;
        if (dn_if.pc !== 32'h0000_3000) begin errors++; $display("FAIL rst_pc got %h exp 00003000", dn_if.pc); end
        checks++;
        if (occ !== 2'd0) begin errors++; $display("FAIL rst_occ got %0d exp 0", occ); end
        checks++;
        if (up_if.ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", up_if.ready); end
        checks++;
        if (dn_if.data !== 128'd0) begin errors++; $display("FAIL rst_data got %h exp 0", dn_if.data); end
    endtask

    task automatic test_stream();
        dn_if.ready = 1'b1;
        drive(1'b1, 32'h0000_3000, EXC_NONE, 1'b0);
        cycle();
        checks++;
        if (dn_if.valid !== 1'b1 || dn_if.pc !== 32'h0000_3000) begin
            errors++;
            $display("FAIL latency got valid %b pc %h exp 1 00003000", dn_if.valid, dn_if.pc);
        end
        drive(1'b1, 32'h0000_3004, EXC_ADEL, 1'b0);
        cycle();
        drive(1'b1, 32'h0000_3008, EXC_NONE, 1'b1);
        cycle();
        checks++;
        if (dn_if.pc !== 32'h0000_3008) begin errors++; $display("FAIL stream_pc got %h exp 00003008", dn_if.pc); end
        drive(1'b0, 32'h0, EXC_NONE, 1'b0);
        cycle();
        checks++;
        if (dn_if.valid !== 1'b0 || dn_if.pc !== 32'h0000_3008 || dn_if.bd !== 1'b1 || dn_if.data !== 128'd0) begin
            errors++;
            $display("FAIL drain_retain got valid %b pc %h bd %b data %h exp 0 00003008 1 0",
                     dn_if.valid, dn_if.pc, dn_if.bd, dn_if.data);
        end
    endtask

    task automatic test_backpressure();
        dn_if.ready = 1'b0;
        drive(1'b1, 32'h0000_3010, EXC_NONE, 1'b0);
        cycle();
        drive(1'b1, 32'h0000_3014, EXC_OV, 1'b1);
        cycle();
        drive(1'b0, 32'h0, EXC_NONE, 1'b0);
        checks++;
        if (occ !== 2'(MAX_OCC)) begin errors++; $display("FAIL bp_occ got %0d exp %0d", occ, MAX_OCC); end
        checks++;
        if (up_if.ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b exp 0", up_if.ready); end
        checks++;
        if (dn_if.pc !== 32'h0000_3010) begin errors++; $display("FAIL bp_hold_pc got %h exp 00003010", dn_if.pc); end
        cycle();
        dn_if.ready = 1'b1;
        cycle();
        cycle();
        cycle();
    endtask

    task automatic test_req();
        dn_if.ready = 1'b0;
        drive(1'b1, 32'h0000_3040, EXC_RI, 1'b1);
        cycle();
        drive(1'b1, 32'h0000_3044, EXC_NONE, 1'b0);
        cycle();
        drive(1'b1, 32'h0000_3048, EXC_NONE, 1'b0);
        req = 1'b1;
        cycle();
        req = 1'b0;
        drive(1'b0, 32'h0, EXC_NONE, 1'b0);
        checks++;
        if (dn_if.valid !== 1'b0) begin errors++; $display("FAIL req_valid got %b exp 0", dn_if.valid); end
        checks++;
        if (dn_if.pc !== 32'h0000_4180) begin errors++; $display("FAIL req_pc got %h exp 00004180", dn_if.pc); end
        checks++;
        if (dn_if.data !== 128'd0 || dn_if.exc !== 5'd0 || dn_if.bd !== 1'b0) begin
            errors++;
            $display("FAIL req_clear got data %h exc %0d bd %b exp 0 0 0", dn_if.data, dn_if.exc, dn_if.bd);
        end
        checks++;
        if (occ !== 2'd0) begin errors++; $display("FAIL req_occ got %0d exp 0", occ); end
        dn_if.ready = 1'b1;
        cycle();
        cycle();
    endtask

    task automatic test_flush();
        dn_if.ready = 1'b0;
        drive(1'b1, 32'h0000_3020, EXC_OV, 1'b1);
        cycle();
        drive(1'b0, 32'h0, EXC_NONE, 1'b0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        checks++;
        if (dn_if.valid !== 1'b0 || occ !== 2'd0) begin
            errors++;
            $display("FAIL flush_valid got valid %b occ %0d exp 0 0", dn_if.valid, occ);
        end
        checks++;
        if (dn_if.data !== 128'd0 || dn_if.exc !== 5'd0) begin
            errors++;
            $display("FAIL flush_clear got data %h exc %0d exp 0 0", dn_if.data, dn_if.exc);
        end
        checks++;
        if (dn_if.pc !== 32'h0000_3020 || dn_if.bd !== 1'b1) begin
            errors++;
            $display("FAIL flush_keep got pc %h bd %b exp 00003020 1", dn_if.pc, dn_if.bd);
        end
        dn_if.ready = 1'b1;
        cycle();
    endtask

    task automatic test_priority();
        dn_if.ready = 1'b0;
        drive(1'b1, 32'h0000_3050, EXC_ADES, 1'b1);
        cycle();
        drive(1'b1, 32'h0000_3054, EXC_NONE, 1'b0);
        req = 1'b1; flush = 1'b1; reset_n = 1'b0;
        cycle();
        req = 1'b0; flush = 1'b0; reset_n = 1'b1;
        drive(1'b0, 32'h0, EXC_NONE, 1'b0);
        checks++;
        if (dn_if.valid !== 1'b0 || dn_if.pc !== 32'h0000_3000 || dn_if.bd !== 1'b0 || occ !== 2'd0) begin
            errors++;
            $display("FAIL prio_reset got valid %b pc %h bd %b occ %0d exp 0 00003000 0 0",
                     dn_if.valid, dn_if.pc, dn_if.bd, occ);
        end
        drive(1'b1, 32'h0000_3058, EXC_NONE, 1'b1);
        cycle();
        drive(1'b0, 32'h0, EXC_NONE, 1'b0);
        req = 1'b1; flush = 1'b1;
        cycle();
        req = 1'b0; flush = 1'b0;
        checks++;
        if (dn_if.valid !== 1'b0 || dn_if.pc !== 32'h0000_4180 || dn_if.bd !== 1'b0) begin
            errors++;
            $display("FAIL prio_req got valid %b pc %h bd %b exp 0 00004180 0", dn_if.valid, dn_if.pc, dn_if.bd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pc;
        pc = 32'h0000_5000;
        for (int i = 0; i < 300; i++) begin
            dn_if.ready = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 3) != 0) begin
                drive(1'b1, pc, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
                pc = pc + 32'd4;
            end else begin
                drive(1'b0, 32'h0, EXC_NONE, 1'b0);
            end
            cycle();
        end
        drive(1'b0, 32'h0, EXC_NONE, 1'b0);
        dn_if.ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        checks++;
        if (occ !== 2'd0 || dn_if.valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_empty got occ %0d valid %b exp 0 0", occ, dn_if.valid);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        req = 1'b0;
        flush = 1'b0;
        dn_if.ready = 1'b0;
        drive(1'b0, 32'h0, EXC_NONE, 1'b0);
        test_reset();
        test_stream();
        test_backpressure();
        test_req();
        test_flush();
        test_priority();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
